// File: rtl/instr_mem_fetch_pkg.sv
// instr_mem_fetch_pkg: shared fetch-stage types and the default boot program.
package instr_mem_fetch_pkg;

    typedef enum logic {RUN, LOAD} state_e;

    localparam int PROG_LEN = 6;
    // Entry 0 is the rightmost element.
    localparam logic [PROG_LEN-1:0][7:0] PROG = {8'd10, 8'd15, 8'd5, 8'd6, 8'd9, 8'd3};

endpackage

// File: rtl/instr_mem_array.sv
// instr_mem_array: DEPTH x DATA_W single-write, single-read synchronous array.
module instr_mem_array
    import instr_mem_fetch_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int IW     = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [IW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [IW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;

    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < DEPTH; i++)
            m[i[IW-1:0]] = (i < PROG_LEN) ? DATA_W'(PROG[i[2:0]]) : '0;
        return m;
    endfunction

    // Storage is never reset; contents survive reset and start from the boot program.
    mem_t mem_q = init_mem();
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_fetch.sv
// instr_mem_fetch: registered instruction memory with valid/ready fetch port
// and a streaming run-time loader.
module instr_mem_fetch
    import instr_mem_fetch_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_valid,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic              instr_fault,
    input  logic              instr_ready,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_busy,
    output logic              load_err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    state_e state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic err_q, err_d, valid_q, valid_d, fault_q, fault_d;
    logic accept, fetch_in_range, ptr_in_range, we;
    logic [DATA_W-1:0] rdata;

    assign fetch_in_range = {1'b0, fetch_addr} < DEPTH_P;
    assign ptr_in_range   = ptr_q < DEPTH_P;
    assign fetch_ready    = (state_q == RUN) && (!valid_q || instr_ready);
    assign accept         = fetch_valid && fetch_ready;
    // A restart pulse in LOAD wins over data arriving in the same cycle.
    assign we             = (state_q == LOAD) && load_valid && !load_start && ptr_in_range;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        err_d   = err_q;
        if (load_start) begin
            state_d = LOAD;
            ptr_d   = '0;
            err_d   = 1'b0;
        end else if (state_q == LOAD && load_valid) begin
            ptr_d   = ptr_in_range ? ptr_q + PW'(1) : ptr_q;
            err_d   = err_q | !ptr_in_range;
            state_d = load_last ? RUN : LOAD;
        end
    end

    assign valid_d = accept || (valid_q && !instr_ready);
    assign fault_d = accept ? !fetch_in_range : fault_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    instr_mem_array #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .clk    (clk),
        .reset  (reset),
        .we_i   (we),
        .waddr_i(ptr_q[IW-1:0]),
        .wdata_i(load_data),
        .re_i   (accept && fetch_in_range),
        .raddr_i(fetch_addr[IW-1:0]),
        .rdata_o(rdata)
    );

    // Faulted results never load the read register, so mask it here.
    assign instr_data  = fault_q ? '0 : rdata;
    assign instr_fault = fault_q;
    assign instr_valid = valid_q;
    assign load_busy   = state_q == LOAD;
    assign load_err    = err_q;

endmodule
